xcorr_sched: RTL and testbench

Sequencing controller for the microphone cross-correlation datapath. On a start command from the AHB register block it sweeps every lag in −MAX_LAG..+MAX_LAG and drives read addresses into the two sample buffers. It accumulates products through a pipelined MAC and tracks the peak. It then publishes the peak lag and value on `max_sequence_x` / `max_sequence_y` for CPU readback.

---
 rtl/xcorr_pkg.sv | 27 ++
 rtl/xcorr_sched_if.sv | 15 +
 rtl/xcorr_mac.sv | 39 +++
 rtl/xcorr_sched.sv | 189 ++++++++++++++++++
 tb/tb_xcorr_sched.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/xcorr_pkg.sv
// Shared types and helpers for the cross-correlation sweep scheduler.
// Holds the FSM state enum, accumulator sizing, saturation limits and lag addressing.
package xcorr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_CMP,
    ST_FIN
  } state_e;

  localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_MIN = 32'h8000_0000;

  // Wide enough that LEN full-scale products can never overflow.
  function automatic int acc_width(int dw, int len);
    return 2 * dw + $clog2(len);
  endfunction

  // Positive lag shifts buffer A forward; negative lag shifts buffer B forward.
  function automatic int lag_addr(int n, int k, bit port_b);
    if (k >= 0) return port_b ? n : n + k;
    else        return port_b ? n - k : n;
  endfunction

endpackage

// File: rtl/xcorr_sched_if.sv
// Read port into the two sample buffers (A and B share one strobe).
// The scheduler drives addresses; the buffers return data one cycle after rd_en.
interface xcorr_sched_if #(
  parameter int DW = 16,
  parameter int AW = 8
);
  logic                 rd_en;
  logic [AW-1:0]        rd_addr_a;
  logic [AW-1:0]        rd_addr_b;
  logic signed [DW-1:0] rd_data_a;
  logic signed [DW-1:0] rd_data_b;

  modport master (output rd_en, rd_addr_a, rd_addr_b, input rd_data_a, rd_data_b);
  modport slave  (input rd_en, rd_addr_a, rd_addr_b, output rd_data_a, rd_data_b);
endinterface

// File: rtl/xcorr_mac.sv
// Pipelined signed multiply-accumulate: one register stage for the product,
// one for the running sum. clr_i zeroes the sum and drops any product in flight.
module xcorr_mac
  import xcorr_pkg::*;
#(
  parameter int DW    = 16,
  parameter int ACC_W = 40
) (
  input  logic                    hclk,
  input  logic                    hresetn,
  input  logic                    clr_i,
  input  logic                    vld_i,
  input  logic signed [DW-1:0]    a_i,
  input  logic signed [DW-1:0]    b_i,
  output logic signed [ACC_W-1:0] acc_o
);

  logic signed [2*DW-1:0]  prod_q;
  logic                    prod_vld_q;
  logic signed [ACC_W-1:0] acc_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      prod_q     <= (2*DW)'(a_i) * (2*DW)'(b_i);
      prod_vld_q <= vld_i & ~clr_i;
      if (clr_i)           acc_q <= '0;
      else if (prod_vld_q) acc_q <= acc_q + ACC_W'(prod_q);
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/xcorr_sched.sv
// Cross-correlation sweep scheduler: walks every lag in -MAX_LAG..+MAX_LAG, feeds the MAC
// and publishes the peak. Build option XCORR_SCHED_ABS_PEAK_EN selects peak by magnitude.
module xcorr_sched
  import xcorr_pkg::*;
#(
  parameter int LEN     = 256,
  parameter int MAX_LAG = 32,
  parameter int DW      = 16,
  parameter int AW      = 8
) (
  input  logic                 hclk,
  input  logic                 hresetn,
  input  logic                 start,
  input  logic                 abort,
  xcorr_sched_if.master        rd,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          max_sequence_x,
  output logic [31:0]          max_sequence_y
);

  localparam int ACC_W = acc_width(DW, LEN);
  localparam int KW    = AW + 1;
  localparam logic signed [KW-1:0] K_MAX = KW'(MAX_LAG);
  localparam logic signed [KW-1:0] K_MIN = -K_MAX;
  localparam logic [AW-1:0]        N_TOP = AW'(LEN - 1);

  state_e state_q, state_d;

  logic signed [KW-1:0]    k_q, k_d;
  logic [AW-1:0]           n_q, n_d;
  logic                    drain_q, drain_d;
  logic                    first_q, first_d;
  logic signed [ACC_W-1:0] best_val_q, best_val_d;
  logic signed [KW-1:0]    best_lag_q, best_lag_d;
  logic [31:0]             max_x_q, max_x_d;
  logic [31:0]             max_y_q, max_y_d;
  logic                    rd_vld_q;
  logic                    mac_clr;

  logic signed [ACC_W-1:0] acc;
  logic [AW-1:0]           abs_k;
  logic                    last_n, last_k;
  logic                    better, upd;
  logic signed [ACC_W-1:0] win_val;
  logic signed [KW-1:0]    win_lag;
  logic [31:0]             win_sat;

  assign abs_k  = k_q[KW-1] ? AW'(-k_q) : AW'(k_q);
  assign last_n = (n_q == N_TOP - abs_k);
  assign last_k = (k_q == K_MAX);

`ifdef XCORR_SCHED_ABS_PEAK_EN
  logic signed [ACC_W-1:0] acc_mag, best_mag;
  assign acc_mag  = acc[ACC_W-1] ? -acc : acc;
  assign best_mag = best_val_q[ACC_W-1] ? -best_val_q : best_val_q;
  assign better   = acc_mag > best_mag;
`else
  assign better   = acc > best_val_q;
`endif

  // Strict compare: on a tie the earlier (more negative) lag is kept.
  assign upd     = first_q | better;
  assign win_val = upd ? acc : best_val_q;
  assign win_lag = upd ? k_q : best_lag_q;

  if (ACC_W > 32) begin : g_sat
    logic ovf;
    assign ovf     = ~(&win_val[ACC_W-1:31]) & (|win_val[ACC_W-1:31]);
    assign win_sat = ovf ? (win_val[ACC_W-1] ? SAT_MIN : SAT_MAX) : win_val[31:0];
  end else begin : g_ext
    assign win_sat = 32'(win_val);
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start)   state_d = ST_ISSUE;
      ST_ISSUE: if (last_n)  state_d = ST_DRAIN;
      ST_DRAIN: if (drain_q) state_d = ST_CMP;
      ST_CMP:   state_d = last_k ? ST_FIN : ST_ISSUE;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Abort overrides everything, including a simultaneous start.
    if (abort) state_d = ST_IDLE;
  end

  always_comb begin
    rd.rd_en     = 1'b0;
    rd.rd_addr_a = '0;
    rd.rd_addr_b = '0;
    busy         = 1'b0;
    done         = 1'b0;
    mac_clr      = (state_q != ST_ISSUE) && (state_d == ST_ISSUE);
    unique case (state_q)
      ST_ISSUE: begin
        rd.rd_en     = 1'b1;
        rd.rd_addr_a = AW'(lag_addr(int'(n_q), int'(k_q), 1'b0));
        rd.rd_addr_b = AW'(lag_addr(int'(n_q), int'(k_q), 1'b1));
        busy         = 1'b1;
      end
      ST_DRAIN, ST_CMP: busy = 1'b1;
      ST_FIN:           done = 1'b1;
      default:          ;
    endcase
  end

  // NOTE: every variable gets a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    k_d        = k_q;
    n_d        = n_q;
    drain_d    = 1'b0;
    first_d    = first_q;
    best_val_d = best_val_q;
    best_lag_d = best_lag_q;
    max_x_d    = max_x_q;
    max_y_d    = max_y_q;
    unique case (state_q)
      ST_IDLE: if (start && !abort) begin
        k_d     = K_MIN;
        n_d     = '0;
        first_d = 1'b1;
      end
      ST_ISSUE: n_d = n_q + AW'(1);
      ST_DRAIN: drain_d = ~drain_q;
      ST_CMP: if (!abort) begin
        best_val_d = win_val;
        best_lag_d = win_lag;
        first_d    = 1'b0;
        n_d        = '0;
        if (last_k) begin
          max_x_d = 32'(win_lag);
          max_y_d = win_sat;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      k_q        <= '0;
      n_q        <= '0;
      drain_q    <= 1'b0;
      first_q    <= 1'b0;
      best_val_q <= '0;
      best_lag_q <= '0;
      max_x_q    <= '0;
      max_y_q    <= '0;
      rd_vld_q   <= 1'b0;
    end else begin
      k_q        <= k_d;
      n_q        <= n_d;
      drain_q    <= drain_d;
      first_q    <= first_d;
      best_val_q <= best_val_d;
      best_lag_q <= best_lag_d;
      max_x_q    <= max_x_d;
      max_y_q    <= max_y_d;
      rd_vld_q   <= rd.rd_en;
    end
  end

  assign max_sequence_x = max_x_q;
  assign max_sequence_y = max_y_q;

  xcorr_mac #(
    .DW    (DW),
    .ACC_W (ACC_W)
  ) u_mac (
    .hclk    (hclk),
    .hresetn (hresetn),
    .clr_i   (mac_clr),
    .vld_i   (rd_vld_q),
    .a_i     (rd.rd_data_a),
    .b_i     (rd.rd_data_b),
    .acc_o   (acc)
  );

endmodule

// File: tb/tb_xcorr_sched.sv
// Directed bench for xcorr_sched: small LEN=8/MAX_LAG=2 instance for function, timing,
// abort and reset; a LEN=256/MAX_LAG=0 instance for output saturation.
module tb_xcorr_sched;

  logic hclk = 1'b0;
  logic hresetn = 1'b0;
  always #5 hclk = ~hclk;

  // Small instance
  logic        start = 1'b0, abort = 1'b0;
  logic        busy, done;
  logic [31:0] max_sequence_x, max_sequence_y;
  xcorr_sched_if #(.DW(16), .AW(3)) bus ();
  logic signed [15:0] mem_a [8];
  logic signed [15:0] mem_b [8];

  xcorr_sched #(.LEN(8), .MAX_LAG(2), .DW(16), .AW(3)) dut (
    .hclk(hclk), .hresetn(hresetn), .start(start), .abort(abort), .rd(bus),
    .busy(busy), .done(done), .max_sequence_x(max_sequence_x), .max_sequence_y(max_sequence_y)
  );

  always @(posedge hclk) begin
    if (bus.rd_en) begin
      bus.rd_data_a <= mem_a[bus.rd_addr_a];
      bus.rd_data_b <= mem_b[bus.rd_addr_b];
    end
  end

  // Saturation instance: both buffers full-scale positive
  logic        s_start = 1'b0;
  logic        s_abort = 1'b0;
  logic        s_busy, s_done;
  logic [31:0] s_x, s_y;
  xcorr_sched_if #(.DW(16), .AW(8)) sbus ();
  assign sbus.rd_data_a = 16'sh7FFF;
  assign sbus.rd_data_b = 16'sh7FFF;

  xcorr_sched #(.LEN(256), .MAX_LAG(0), .DW(16), .AW(8)) dut_sat (
    .hclk(hclk), .hresetn(hresetn), .start(s_start), .abort(s_abort), .rd(sbus),
    .busy(s_busy), .done(s_done), .max_sequence_x(s_x), .max_sequence_y(s_y)
  );

  int passed = 0;
  int total  = 0;

  // Results of the last sweep() call
  int       r_busy, r_done;
  logic     r_busy_at_done, r_stable, r_busy_after_abort;
  logic [2:0] rd_a_q[$];
  logic [2:0] rd_b_q[$];

  task automatic load_impulse();
    for (int i = 0; i < 8; i++) begin mem_a[i] = 16'sd0; mem_b[i] = 16'sd0; end
    mem_a[5] = 16'sd100;
    mem_b[3] = 16'sd50;
  endtask

  task automatic load_tie();
    for (int i = 0; i < 8; i++) begin mem_a[i] = 16'sd0; mem_b[i] = 16'sd0; end
    mem_a[1] = -16'sd7;
    mem_b[3] = 16'sd9;
  endtask

  // Pulse start, then watch one cycle per negedge until done or the limit.
  // Index 0 is the cycle right after the edge that samples start.
  task automatic sweep(input int abort_at, input int restart_at, input int limit);
    logic [31:0] x0, y0;
    @(negedge hclk); start = 1'b1;
    @(negedge hclk); start = 1'b0;
    r_busy = 0; r_done = 0;
    r_busy_at_done = 1'b1; r_stable = 1'b1; r_busy_after_abort = 1'b1;
    rd_a_q.delete(); rd_b_q.delete();
    x0 = max_sequence_x; y0 = max_sequence_y;
    for (int i = 0; i < limit; i++) begin
      if (busy) r_busy++;
      if (bus.rd_en) begin rd_a_q.push_back(bus.rd_addr_a); rd_b_q.push_back(bus.rd_addr_b); end
      if (busy && (max_sequence_x !== x0 || max_sequence_y !== y0)) r_stable = 1'b0;
      if (abort_at >= 0 && i == abort_at + 1) begin abort = 1'b0; r_busy_after_abort = busy; end
      if (done) begin r_done++; r_busy_at_done = busy; break; end
      if (i == abort_at) abort = 1'b1;
      start = (i == restart_at);
      @(negedge hclk);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    hresetn = 1'b0;
    repeat (2) @(negedge hclk);
    total++; if (bus.rd_en !== 1'b0) $display("FAIL reset_rd_en: got %0b want 0", bus.rd_en); else passed++;
    total++; if (bus.rd_addr_a !== 3'd0) $display("FAIL reset_addr_a: got %0d want 0", bus.rd_addr_a); else passed++;
    total++; if (bus.rd_addr_b !== 3'd0) $display("FAIL reset_addr_b: got %0d want 0", bus.rd_addr_b); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %0b want 0", done); else passed++;
    total++; if (max_sequence_x !== 32'd0) $display("FAIL reset_max_x: got %h want 0", max_sequence_x); else passed++;
    total++; if (max_sequence_y !== 32'd0) $display("FAIL reset_max_y: got %h want 0", max_sequence_y); else passed++;
    hresetn = 1'b1;
    @(negedge hclk);
  endtask

  // Only lag +2 overlaps a[5] with b[3]: 100*50 = 5000.
  // Busy cycles: (6+3)+(7+3)+(8+3)+(7+3)+(6+3) = 49.
  task automatic test_impulse();
    load_impulse();
    sweep(-1, -1, 200);
    total++; if (r_done !== 1) $display("FAIL impulse_done: got %0d pulses want 1", r_done); else passed++;
    total++; if (r_busy !== 49) $display("FAIL impulse_busy_cycles: got %0d want 49", r_busy); else passed++;
    total++; if (r_busy_at_done !== 1'b0) $display("FAIL impulse_busy_in_fin: got %0b want 0", r_busy_at_done); else passed++;
    total++; if (r_stable !== 1'b1) $display("FAIL impulse_outputs_stable: got %0b want 1", r_stable); else passed++;
    total++; if (max_sequence_x !== 32'd2) $display("FAIL impulse_lag: got %h want 2", max_sequence_x); else passed++;
    total++; if (max_sequence_y !== 32'd5000) $display("FAIL impulse_value: got %0d want 5000", max_sequence_y); else passed++;
    @(negedge hclk);
    total++; if (done !== 1'b0) $display("FAIL impulse_done_width: got %0b want 0", done); else passed++;
  endtask

  // Reads from the previous sweep: lag -2 is 6 reads, lag -1 is the next 7.
  task automatic test_address();
    total++; if (rd_a_q.size() !== 34) $display("FAIL addr_count: got %0d want 34", rd_a_q.size()); else passed++;
    if (rd_a_q.size() == 34) begin
      total++;
      if (rd_a_q[0] !== 3'd0 || rd_b_q[0] !== 3'd2)
        $display("FAIL addr_lag_m2_first: got (%0d,%0d) want (0,2)", rd_a_q[0], rd_b_q[0]);
      else passed++;
      for (int n = 0; n < 7; n++) begin
        total++;
        if (rd_a_q[6+n] !== 3'(n) || rd_b_q[6+n] !== 3'(n+1))
          $display("FAIL addr_lag_m1_n%0d: got (%0d,%0d) want (%0d,%0d)", n, rd_a_q[6+n], rd_b_q[6+n], n, n+1);
        else passed++;
      end
      total++;
      if (rd_a_q[28] !== 3'd2 || rd_b_q[28] !== 3'd0)
        $display("FAIL addr_lag_p2_first: got (%0d,%0d) want (2,0)", rd_a_q[28], rd_b_q[28]);
      else passed++;
    end
  endtask

  // Lag -2 gives -63 (a[1]*b[3]); every other lag gives 0. Signed: lag -1's 0 beats -63
  // and later zeros only tie. Magnitude: only lag -2 is non-zero.
  task automatic test_tie_then_back_to_back();
    logic [31:0] exp_x, exp_y;
`ifdef XCORR_SCHED_ABS_PEAK_EN
    exp_x = 32'hFFFF_FFFE; exp_y = 32'hFFFF_FFC1;
`else
    exp_x = 32'hFFFF_FFFF; exp_y = 32'h0000_0000;
`endif
    load_tie();
    sweep(-1, -1, 200);
    total++; if (r_done !== 1) $display("FAIL tie_done: got %0d want 1", r_done); else passed++;
    total++; if (max_sequence_x !== exp_x) $display("FAIL tie_lag: got %h want %h", max_sequence_x, exp_x); else passed++;
    total++; if (max_sequence_y !== exp_y) $display("FAIL tie_value: got %h want %h", max_sequence_y, exp_y); else passed++;
    load_impulse();
    sweep(-1, -1, 200);
    total++; if (r_busy !== 49) $display("FAIL b2b_busy_cycles: got %0d want 49", r_busy); else passed++;
    total++; if (max_sequence_x !== 32'd2) $display("FAIL b2b_lag: got %h want 2", max_sequence_x); else passed++;
    total++; if (max_sequence_y !== 32'd5000) $display("FAIL b2b_value: got %0d want 5000", max_sequence_y); else passed++;
  endtask

  task automatic test_abort_and_restart();
    sweep(9, -1, 80);
    total++; if (r_busy_after_abort !== 1'b0) $display("FAIL abort_busy_drop: got %0b want 0", r_busy_after_abort); else passed++;
    total++; if (r_busy !== 10) $display("FAIL abort_busy_cycles: got %0d want 10", r_busy); else passed++;
    total++; if (r_done !== 0) $display("FAIL abort_no_done: got %0d want 0", r_done); else passed++;
    total++; if (max_sequence_x !== 32'd2) $display("FAIL abort_keeps_lag: got %h want 2", max_sequence_x); else passed++;
    total++; if (max_sequence_y !== 32'd5000) $display("FAIL abort_keeps_value: got %0d want 5000", max_sequence_y); else passed++;
    sweep(-1, 5, 200);
    total++; if (r_busy !== 49) $display("FAIL restart_ignored_cycles: got %0d want 49", r_busy); else passed++;
    total++; if (r_done !== 1) $display("FAIL restart_ignored_done: got %0d want 1", r_done); else passed++;
    total++; if (max_sequence_y !== 32'd5000) $display("FAIL restart_ignored_value: got %0d want 5000", max_sequence_y); else passed++;
  endtask

  task automatic test_reset_mid_sweep();
    @(negedge hclk); start = 1'b1;
    @(negedge hclk); start = 1'b0;
    repeat (3) @(negedge hclk);
    total++; if (bus.rd_en !== 1'b1) $display("FAIL midreset_in_issue: got %0b want 1", bus.rd_en); else passed++;
    hresetn = 1'b0;
    #1;
    total++;
    if (bus.rd_en !== 1'b0 || bus.rd_addr_a !== 3'd0 || bus.rd_addr_b !== 3'd0 || busy !== 1'b0 ||
        done !== 1'b0 || max_sequence_x !== 32'd0 || max_sequence_y !== 32'd0)
      $display("FAIL midreset_outputs: got en=%0b a=%0d b=%0d busy=%0b done=%0b x=%h y=%h want all 0",
               bus.rd_en, bus.rd_addr_a, bus.rd_addr_b, busy, done, max_sequence_x, max_sequence_y);
    else passed++;
    @(negedge hclk); hresetn = 1'b1;
    sweep(-1, -1, 200);
    total++; if (max_sequence_x !== 32'd2) $display("FAIL midreset_rerun_lag: got %h want 2", max_sequence_x); else passed++;
    total++; if (max_sequence_y !== 32'd5000) $display("FAIL midreset_rerun_value: got %0d want 5000", max_sequence_y); else passed++;
  endtask

  // 256 * 0x7FFF^2 far exceeds 2^31-1, so the output clamps.
  task automatic test_saturation();
    int cyc = 0;
    int seen = 0;
    @(negedge hclk); s_start = 1'b1;
    @(negedge hclk); s_start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (s_busy) cyc++;
      if (s_done) begin seen = 1; break; end
      @(negedge hclk);
    end
    total++; if (seen !== 1) $display("FAIL sat_done: got %0d want 1", seen); else passed++;
    total++; if (cyc !== 259) $display("FAIL sat_busy_cycles: got %0d want 259", cyc); else passed++;
    total++; if (s_y !== 32'h7FFF_FFFF) $display("FAIL sat_value: got %h want 7fffffff", s_y); else passed++;
    total++; if (s_x !== 32'd0) $display("FAIL sat_lag: got %h want 0", s_x); else passed++;
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_address();
    test_tie_then_back_to_back();
    test_abort_and_restart();
    test_reset_mid_sweep();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
